// File: rtl/alu_issue_pkg.sv
// Shared opcode/funct constants, ALU funct codes, FSM states and the
// decoded-op bundle used by the ALU issue stage.
`ifndef ALU_ADDU
`define ALU_ADDU 4'd0
`define ALU_SUBU 4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_NOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_LUI  4'd11
`define ALU_EQ   4'd12
`define ALU_NEQ  4'd13
`endif

package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        wen;
    logic        illegal;
  } issue_t;

  function automatic issue_t illegal_op();
    issue_t r;
    r         = '0;
    r.funct   = `ALU_ADDU;
    r.illegal = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational MIPS instruction decode into ALU funct, operands,
// destination and write-enable.
module alu_issue_stage_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output issue_t      dec
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sh;
  logic [31:0] simm;
  logic [31:0] zimm;
  logic        unused_rs;

  assign op        = instr[31:26];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign sh        = instr[10:6];
  assign fn        = instr[5:0];
  assign simm      = {{16{instr[15]}}, instr[15:0]};
  assign zimm      = {16'h0000, instr[15:0]};
  assign unused_rs = ^instr[25:21];

  always_comb begin
    dec       = '0;
    dec.funct = `ALU_ADDU;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        dec.op1  = rs_val;
        dec.op2  = rt_val;
        dec.dest = rd;
        dec.wen  = 1'b1;
        unique case (fn)
          FN_ADDU: dec.funct = `ALU_ADDU;
          FN_SUBU: dec.funct = `ALU_SUBU;
          FN_AND:  dec.funct = `ALU_AND;
          FN_OR:   dec.funct = `ALU_OR;
          FN_XOR:  dec.funct = `ALU_XOR;
          FN_NOR:  dec.funct = `ALU_NOR;
          FN_SLT:  dec.funct = `ALU_SLT;
          FN_SLTU: dec.funct = `ALU_SLTU;
          FN_SLL: begin
            dec.funct = `ALU_SLL;
            dec.shamt = sh;
          end
          FN_SRL: begin
            dec.funct = `ALU_SRL;
            dec.shamt = sh;
          end
          FN_SRA: begin
            dec.funct = `ALU_SRA;
            dec.shamt = sh;
          end
          default: dec = illegal_op();
        endcase
      end
      (op == OP_BEQ), (op == OP_BNE): begin
        dec.funct = (op == OP_BEQ) ? `ALU_EQ : `ALU_NEQ;
        dec.op1   = rs_val;
        dec.op2   = rt_val;
      end
      (op == OP_ADDIU), (op == OP_SLTI),
      (op == OP_SLTIU): begin
        dec.op1  = rs_val;
        dec.op2  = simm;
        dec.dest = rt;
        dec.wen  = 1'b1;
        dec.funct = (op == OP_ADDIU) ? `ALU_ADDU :
                    (op == OP_SLTI)  ? `ALU_SLT  :
                                       `ALU_SLTU;
      end
      (op == OP_ANDI), (op == OP_ORI),
      (op == OP_XORI), (op == OP_LUI): begin
        dec.op1  = rs_val;
        dec.op2  = zimm;
        dec.dest = rt;
        dec.wen  = 1'b1;
        dec.funct = (op == OP_ANDI) ? `ALU_AND :
                    (op == OP_ORI)  ? `ALU_OR  :
                    (op == OP_XORI) ? `ALU_XOR :
                                      `ALU_LUI;
      end
      default: dec = illegal_op();
    endcase
    // r0 is never written, which also turns the all-zero SLL into a NOP
    if (dec.dest == 5'd0) dec.wen = 1'b0;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode + registered 2-entry skid buffer.
// Define ALU_ISSUE_STATS_EN to add issued/illegal transfer counters.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [DW-1:0] rs_val,
  input  logic [DW-1:0] rt_val,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_funct,
  output logic [DW-1:0] out_op1,
  output logic [DW-1:0] out_op2,
  output logic [4:0]    out_shamt,
  output logic [RW-1:0] out_dest,
  output logic          out_wen,
  output logic          out_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_illegal
`endif
);

  issue_t dec;
  issue_t main_q;
  issue_t skid_q;
  state_t state_q;
  state_t state_d;
  logic   rdy_q;
  logic   vld_q;
  logic   rdy_d;
  logic   vld_d;
  logic   in_fire;
  logic   out_fire;
  logic   ld_main;
  logic   ld_skid;
  logic   mv_skid;

  alu_issue_stage_decode u_dec (
    .instr  (instr),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .dec    (dec)
  );

  assign in_fire  = in_valid && rdy_q;
  assign out_fire = vld_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      if (ld_main)      main_q <= dec;
      else if (mv_skid) main_q <= skid_q;
      if (ld_skid)      skid_q <= dec;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d = ST_ONE;
          ld_main = 1'b1;
        end
      end
      ST_ONE: begin
        unique case ({in_fire, out_fire})
          2'b10: begin
            state_d = ST_TWO;
            ld_skid = 1'b1;
          end
          2'b11:   ld_main = 1'b1;
          2'b01:   state_d = ST_EMPTY;
          default: state_d = ST_ONE;
        endcase
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d = ST_ONE;
          mv_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // handshake flags are precomputed from the next state so they leave flops
  always_comb begin
    rdy_d = (state_d != ST_TWO);
    vld_d = (state_d != ST_EMPTY);
  end

  assign in_ready    = rdy_q;
  assign out_valid   = vld_q;
  assign out_funct   = main_q.funct;
  assign out_op1     = main_q.op1;
  assign out_op2     = main_q.op2;
  assign out_shamt   = main_q.shamt;
  assign out_dest    = main_q.dest;
  assign out_wen     = main_q.wen;
  assign out_illegal = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued  <= '0;
      stat_illegal <= '0;
    end else if (out_fire) begin
      stat_issued <= stat_issued + 32'd1;
      if (main_q.illegal) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
// Drives on negedge, samples 1ns after posedge or at negedge.
module tb_alu_issue_stage;

  localparam logic [3:0] F_ADDU = 4'd0;
  localparam logic [3:0] F_SUBU = 4'd1;
  localparam logic [3:0] F_OR   = 4'd3;
  localparam logic [3:0] F_SLL  = 4'd8;
  localparam logic [3:0] F_LUI  = 4'd11;
  localparam logic [3:0] F_EQ   = 4'd12;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_funct;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [4:0]  out_shamt;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_illegal;

  int errors;
  int checks;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_funct   (out_funct),
    .out_op1     (out_op1),
    .out_op2     (out_op2),
    .out_shamt   (out_shamt),
    .out_dest    (out_dest),
    .out_wen     (out_wen),
    .out_illegal (out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag,
                            input logic [3:0] f,
                            input logic [31:0] a,
                            input logic [31:0] b,
                            input logic [4:0] sh,
                            input logic [4:0] d,
                            input logic w,
                            input logic ill);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".funct"}, {28'd0, out_funct}, {28'd0, f});
    check({tag, ".op1"}, out_op1, a);
    check({tag, ".op2"}, out_op2, b);
    check({tag, ".shamt"}, {27'd0, out_shamt}, {27'd0, sh});
    check({tag, ".dest"}, {27'd0, out_dest}, {27'd0, d});
    check({tag, ".wen"}, {31'd0, out_wen}, {31'd0, w});
    check({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, ".funct"}, {28'd0, out_funct}, 32'd0);
    check({tag, ".op1"}, out_op1, 32'd0);
    check({tag, ".op2"}, out_op2, 32'd0);
    check({tag, ".dest"}, {27'd0, out_dest}, 32'd0);
    check({tag, ".wen"}, {31'd0, out_wen}, 32'd0);
  endtask

  // call just after a negedge; returns 1ns after the accepting edge
  task automatic send(input string tag, input logic [31:0] i,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    rs_val   = a;
    rt_val   = b;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    rs_val    = '0;
    rt_val    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    @(negedge clk);
    send("addu", 32'h00221821, 32'd5, 32'd7);
    expect_out("addu", F_ADDU, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    send("addiu", 32'h2422FFFF, 32'd10, 32'd0);
    expect_out("addiu", F_ADDU, 32'd10, 32'hFFFFFFFF, 5'd0, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    send("lui", 32'h3C051234, 32'd0, 32'd0);
    expect_out("lui", F_LUI, 32'd0, 32'h00001234, 5'd0, 5'd5, 1'b1, 1'b0);
    @(negedge clk);
    send("sll", 32'h00022100, 32'd0, 32'd1);
    expect_out("sll", F_SLL, 32'd0, 32'd1, 5'd4, 5'd4, 1'b1, 1'b0);
    @(negedge clk);
    send("nop", 32'h00000000, 32'd3, 32'd3);
    expect_out("nop", F_SLL, 32'd3, 32'd3, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    send("ori", 32'h3423F000, 32'd1, 32'd0);
    expect_out("ori", F_OR, 32'd1, 32'h0000F000, 5'd0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    send("beq", 32'h10220005, 32'd8, 32'd9);
    expect_out("beq", F_EQ, 32'd8, 32'd9, 5'd0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    send("ill", 32'hFC000000, 32'd9, 32'd9);
    expect_out("ill", F_ADDU, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    send("subu", 32'h00223023, 32'd20, 32'd3);
    expect_out("subu", F_SUBU, 32'd20, 32'd3, 5'd0, 5'd6, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("drain.valid", {31'd0, out_valid}, 32'd0);

    // backpressure: A, B fill the buffer, C must wait
    @(negedge clk);
    out_ready = 1'b0;
    send("bpA", 32'h00221821, 32'd1, 32'd2);
    expect_out("bpA", F_ADDU, 32'd1, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    send("bpB", 32'h00223023, 32'd4, 32'd5);
    expect_out("bpA.hold", F_ADDU, 32'd1, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0);
    check("bp.full", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 32'h3427F000;
    rs_val   = 32'd6;
    rt_val   = 32'd0;
    @(posedge clk);
    #1;
    check("bp.full2", {31'd0, in_ready}, 32'd0);
    expect_out("bpA.hold2", F_ADDU, 32'd1, 32'd2, 5'd0, 5'd3, 1'b1, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    expect_out("bpB", F_SUBU, 32'd4, 32'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    check("bp.ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("bpC", F_OR, 32'd6, 32'h0000F000, 5'd0, 5'd7, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("bp.empty", {31'd0, out_valid}, 32'd0);

    // reset with both entries occupied
    @(negedge clk);
    out_ready = 1'b0;
    send("rsA", 32'h00221821, 32'd1, 32'd2);
    @(negedge clk);
    send("rsB", 32'h00223023, 32'd4, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("postrst");
    send("after", 32'h00221821, 32'd5, 32'd7);
    expect_out("after", F_ADDU, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("after.drain", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Front end of the ALU interface; drives the ALU's operand1/operand2/shamt/funct inputs.
- Takes a MIPS instruction plus register-file read values through a valid/ready handshake.
- Decodes the instruction into an `ALU_* funct code, builds the operands (immediate extension), destination register and write-enable.
- Issues them through a registered 2-entry skid buffer, so both in_ready and every output are flop-driven.

Parameters:
- DW, 32: operand/data width; only 32 is supported.
- RW, 5: register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents an instruction.
- in_ready  out  1  stage can accept; registered.
- instr  in  32  MIPS instruction word.
- rs_val  in  32  value of register rs.
- rt_val  in  32  value of register rt.
- out_valid  out  1  issued op valid.
- out_ready  in  1  ALU/execute side accepts.
- out_funct  out  4  `ALU_* code for the ALU funct input.
- out_op1  out  32  ALU operand1.
- out_op2  out  32  ALU operand2.
- out_shamt  out  5  ALU shamt.
- out_dest  out  5  destination register index.
- out_wen  out  1  result is written back.
- out_illegal  out  1  unsupported instruction; funct = `ALU_ADDU, wen = 0.

Behaviour:
- Reset (async assert, sync release): state EMPTY, in_ready = 1, out_valid = 0; all data outputs are 0.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency: one cycle from input transfer to out_valid.
- FSM states:
  - EMPTY: in_ready = 1, out_valid = 0.
  - ONE: main register full; in_ready = 1, out_valid = 1.
  - TWO: main and skid registers full; in_ready = 0, out_valid = 1.
- Transitions:
  - EMPTY + in -> ONE.
  - ONE + in, no out -> TWO; the new entry goes to the skid register.
  - ONE + in + out -> ONE; main register reloads.
  - ONE + out, no in -> EMPTY.
  - TWO + out -> ONE; skid moves to main.
  - No input is accepted in TWO.
- Ordering: strictly FIFO; no entry is dropped or duplicated.
- Outputs hold stable while out_valid && !out_ready.
- Decode for R-type (op 0x00), by instr[5:0]:
  - 0x21 ADDU, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA; shamt = instr[10:6].
  - Operands: op1 = rs_val, op2 = rt_val, dest = rd, wen = 1.
  - Exception: SLL with dest 0 (NOP) sets wen = 0.
- Decode for I-type (op1 = rs_val, dest = rt, wen = 1):
  - ADDIU 0x09: ADDU, op2 = sign-extended imm.
  - SLTI 0x0A: SLT, op2 = sign-extended imm.
  - SLTIU 0x0B: SLTU, op2 = sign-extended imm.
  - ANDI 0x0C: AND, op2 = zero-extended imm.
  - ORI 0x0D: OR, op2 = zero-extended imm.
  - XORI 0x0E: XOR, op2 = zero-extended imm.
  - LUI 0x0F: LUI, op2 = zero-extended imm.
- Branches: BEQ 0x04 -> EQ and BNE 0x05 -> NEQ; op2 = rt_val, wen = 0.
- Shamt for all non-shift ops is 0.
- Any other encoding: illegal = 1, wen = 0, op1/op2 = 0; the entry still flows through the buffer.
- Destination register 0 always forces wen = 0.
- Reset mid-operation: both entries are discarded immediately; state goes to EMPTY.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined: adds outputs stat_issued[31:0] and stat_illegal[31:0].
  - stat_issued increments on each output transfer; stat_illegal increments on each output transfer with out_illegal = 1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: no counters, no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package: `ALU_* codes stay in GLOBAL.v; add opcode/funct constants (OP_RTYPE, OP_ADDIU ... FN_SRA) and the FSM state encodings.
- Sub-module alu_issue_decode: purely combinational instr/rs_val/rt_val -> decoded fields, instantiated once at the input.

Test Plan:
- Reset sequencing: assert rst mid-stream, then release -> out_valid = 0, in_ready = 1, all outputs 0; the next accepted instruction appears after 1 cycle.
- addu $3,$1,$2:
  - Stimulus: instr 0x00221821, rs 5, rt 7.
  - Response: funct ADDU, op1 5, op2 7, dest 3, wen 1.
- addiu $2,$1,-1 then lui $5,0x1234:
  - Stimulus: instr 0x2422FFFF, then 0x3C051234.
  - Response: op2 0xFFFFFFFF with ADDU; then op2 0x00001234 with LUI, dest 5.
- sll $4,$2,4:
  - Stimulus: instr 0x00022100, rt 1.
  - Response: funct SLL, shamt 4, op2 1; instr 0x00000000 -> wen 0.
- Backpressure:
  - Stimulus: out_ready = 0 while 3 back-to-back ops are offered.
  - Response: two are accepted, in_ready drops to 0 after the second, outputs stay stable.
  - Then raise out_ready: ops drain in order and the third is accepted.
- Illegal: instr 0xFC000000 -> out_illegal 1, wen 0, funct ADDU; the following legal op is unaffected.
